// File: rtl/score_keeper_pkg.sv
// Game-level shared types: top game state, score_keeper FSM states, and ball
// geometry defaults that the ball controller and score_keeper must agree on.
package score_keeper_pkg;
  localparam int BALL_SIZE_DEF   = 15;
  localparam int EDGE_MARGIN_DEF = 8;

  typedef enum logic [1:0] {
    MENU_START = 2'd0,
    PLAY       = 2'd1,
    GAME_OVER  = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } sk_state_t;
endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the video pipeline and the game core.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/score_counter.sv
// One player's 4-bit saturating score with clear and win detect; score updates 1 clk after inc.
// win is combinational and reflects the post-increment score; WIN_BY_TWO_EN adds the lead rule.
module score_counter #(
  parameter int WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
`ifdef WIN_BY_TWO_EN
  input  logic [3:0] other_score,
`endif
  output logic [3:0] score,
  output logic       win
);
  logic [3:0] score_inc;

  assign score_inc = (score == 4'd15) ? score : score + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      score <= '0;
    else if (clr) score <= '0;
    else if (inc) score <= score_inc;
  end

`ifdef WIN_BY_TWO_EN
  // At saturation the two-point lead can no longer grow, so being ahead at 15 is enough.
  logic [4:0] lead_need;
  assign lead_need = {1'b0, other_score} + 5'd2;
  assign win = ((score_inc >= 4'(WIN_SCORE)) && ({1'b0, score_inc} >= lead_need))
            || ((score_inc == 4'd15) && (score_inc > other_score));
`else
  assign win = (score_inc >= 4'(WIN_SCORE));
`endif
endmodule

// File: rtl/score_keeper.sv
// Credits points when the ball exits either edge; goal/match flags registered, 1 clk after the tick.
// No backpressure; serve_hold pauses scoring after a goal. Macro WIN_BY_TWO_EN selects win-by-two.
module score_keeper
  import vga_pkg::*;
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 60,
  parameter int EDGE_MARGIN = EDGE_MARGIN_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [1:0]  state,
  input  logic [10:0] x_ball,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        goal_left,
  output logic        goal_right,
  output logic        serve_hold,
  output logic        match_over,
  output logic        winner
);
  localparam logic [10:0] LEFT_LIM  = 11'(EDGE_MARGIN);
  localparam logic [10:0] RIGHT_LIM = 11'(HOR_PIXELS - BALL_SIZE - EDGE_MARGIN);

  sk_state_t  fsm, fsm_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       goal_left_nxt, goal_right_nxt, match_over_nxt, winner_nxt;
  logic       inc_left, inc_right, clr, win_left, win_right;
  logic       in_left, in_right;

  assign in_left    = (x_ball <= LEFT_LIM);
  assign in_right   = (x_ball >= RIGHT_LIM);
  assign clr        = (state == MENU_START);
  assign serve_hold = (fsm == HOLD);

  score_counter #(.WIN_SCORE(WIN_SCORE)) u_left (
    .clk(clk), .rst(rst), .inc(inc_left), .clr(clr),
`ifdef WIN_BY_TWO_EN
    .other_score(score_right),
`endif
    .score(score_left), .win(win_left)
  );

  score_counter #(.WIN_SCORE(WIN_SCORE)) u_right (
    .clk(clk), .rst(rst), .inc(inc_right), .clr(clr),
`ifdef WIN_BY_TWO_EN
    .other_score(score_left),
`endif
    .score(score_right), .win(win_right)
  );

  always_comb begin
    fsm_nxt        = fsm;
    hold_cnt_nxt   = hold_cnt;
    goal_left_nxt  = 1'b0;
    goal_right_nxt = 1'b0;
    match_over_nxt = match_over;
    winner_nxt     = winner;
    inc_left       = 1'b0;
    inc_right      = 1'b0;
    case (fsm)
      IDLE: if (state == PLAY) fsm_nxt = ARMED;
      ARMED: begin
        if (state != PLAY) begin
          fsm_nxt = IDLE;
        end else if (timing_tick && in_left) begin
          // Left zone wins ties: the ball left on the left, so the right player scores.
          inc_right      = 1'b1;
          goal_right_nxt = 1'b1;
          if (win_right) begin
            match_over_nxt = 1'b1;
            winner_nxt     = 1'b1;
            fsm_nxt        = DONE;
          end else begin
            hold_cnt_nxt = 8'(SERVE_TICKS);
            fsm_nxt      = HOLD;
          end
        end else if (timing_tick && in_right) begin
          inc_left      = 1'b1;
          goal_left_nxt = 1'b1;
          if (win_left) begin
            match_over_nxt = 1'b1;
            winner_nxt     = 1'b0;
            fsm_nxt        = DONE;
          end else begin
            hold_cnt_nxt = 8'(SERVE_TICKS);
            fsm_nxt      = HOLD;
          end
        end
      end
      HOLD: begin
        if (state != PLAY) begin
          hold_cnt_nxt = '0;
          fsm_nxt      = IDLE;
        end else if (timing_tick) begin
          // The final tick of the pause also re-arms, provided the ball is back in the field.
          if (hold_cnt > 8'd1) begin
            hold_cnt_nxt = hold_cnt - 8'd1;
          end else begin
            hold_cnt_nxt = '0;
            if (!in_left && !in_right) fsm_nxt = ARMED;
          end
        end
      end
      DONE: begin
        if (clr) begin
          match_over_nxt = 1'b0;
          winner_nxt     = 1'b0;
          fsm_nxt        = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      hold_cnt   <= '0;
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      match_over <= 1'b0;
      winner     <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      hold_cnt   <= hold_cnt_nxt;
      goal_left  <= goal_left_nxt;
      goal_right <= goal_right_nxt;
      match_over <= match_over_nxt;
      winner     <= winner_nxt;
    end
  end
endmodule
